mult_arbiter: RTL and testbench
===============================

Name: mult_arbiter

Overview:
- Round-robin arbiter that shares one iterative 8x8 `mult` instance between N requesters.
- Each requester raises a level request with its operands. The arbiter grants one requester, latches its operands and sequences the multiplier's start/busy handshake. It then returns the 16-bit product with a one-cycle done pulse to the granted requester only.
- Sits between the client blocks and the single `mult` datapath.

Parameters:
- N, 4, number of requesters (2..8).
- IDW, 3, width of the granted-index output; must satisfy 2^IDW >= N.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- req_bi  input  N  per-requester request level; bit k = requester k.
- a_bi  input  8*N  requester operand A, flattened; slice [8k+7:8k] = requester k.
- b_bi  input  8*N  requester operand B, flattened, same packing as a_bi.
- done_bo  output  N  one-hot, one-cycle pulse to the requester whose result is on y_bo.
- y_bo  output  16  product of the last completed job; held until the next completion.
- gnt_idx_bo  output  IDW  index of the current or last granted requester.
- busy_o  output  1  high from grant through the done cycle, inclusive.
- mult_a_bo  output  8  operand A to the multiplier.
- mult_b_bo  output  8  operand B to the multiplier.
- mult_start_o  output  1  start strobe to the multiplier.
- mult_busy_i  input  1  multiplier busy_o.
- mult_y_bi  input  16  multiplier y_bo.

Behaviour:
- Reset (reset=0, asynchronous) forces:
  - state=IDLE, rr_ptr=0;
  - done_bo=0, y_bo=0, gnt_idx_bo=0, busy_o=0;
  - mult_a_bo=0, mult_b_bo=0, mult_start_o=0.
- Multiplier contract:
  - The multiplier samples operands on the edge where start=1.
  - Its busy rises on the following edge, stays high for the computation, then falls.
  - Its y is valid in the first cycle busy is low after having been high.
- FSM states: IDLE, ISSUE, WAIT_HI, WAIT_LO, RESP.
- IDLE:
  - If any req_bi bit is set, pick the first set bit searching rr_ptr, rr_ptr+1, ..., N-1, 0, ... (wrap-around).
  - Latch that requester's a/b into mult_a_bo/mult_b_bo and its index into gnt_idx_bo.
  - Set busy_o=1 and go to ISSUE.
  - If no request is set, stay in IDLE with outputs unchanged.
- ISSUE:
  - mult_start_o=1 for exactly this one cycle; go to WAIT_HI.
  - Operands stay stable from ISSUE through RESP.
- WAIT_HI: wait for mult_busy_i=1, then go to WAIT_LO. There is no timeout.
- WAIT_LO: on mult_busy_i=0:
  - capture mult_y_bi into y_bo;
  - set done_bo bit gnt_idx_bo for one cycle;
  - go to RESP.
- RESP:
  - done_bo returns to 0 and busy_o returns to 0.
  - rr_ptr = gnt_idx_bo+1, wrapping to 0 at N.
  - Go to IDLE.
  - Re-arbitration happens in IDLE on the next cycle.
- Latency:
  - Grant edge to start: 1 cycle.
  - done pulse appears 1 cycle after the multiplier busy falls.
  - Minimum turnaround between two jobs: one IDLE cycle.
- Requester rules:
  - A requester holds req high until it sees its done bit.
  - It must drop req in the cycle after done, otherwise it is re-queued in fair order.
- Operand and request changes:
  - Operand changes after grant are ignored, because operands are latched.
  - A granted requester dropping req mid-job does not abort the job; done still pulses.
- Fairness:
  - Simultaneous requests are granted in rotating order.
  - With all N requesting continuously, each is served exactly once per N jobs.
- Reset mid-job: returns to IDLE immediately. No done is issued, the job is lost and rr_ptr returns to 0.
- Width rule: y_bo is the unmodified 16-bit multiplier output. No truncation or sign handling; operands are unsigned.

Test Plan:
- Reset: hold reset=0 with random inputs -> all outputs 0. Release with req_bi=0 -> state stays IDLE, mult_start_o never pulses.
- Single request: req_bi=0001, a=8, b=8 -> mult_a_bo=8, mult_b_bo=8, mult_start_o single pulse; after the multiplier completes, y_bo=64, done_bo=0001 for one cycle, busy_o low after.
- Simultaneous: req_bi=1111 held, operands (3,5),(7,9),(255,255),(0,200) -> grants in order 0,1,2,3,0. Results 15, 63, 65025, 0, each with the matching one-hot done.
- Wrap-around and skip: after serving requester 2, raise req_bi=0011 -> next grant is 0, then 1.
- Operand change mid-job: grant requester 1 with (12,12), then change a_bi slice to 1 during WAIT_LO -> y_bo=144.
- Reset mid-job: assert reset=0 during WAIT_LO -> no done pulse, outputs 0. After release with req_bi=0100 -> grant index 2, job completes normally.

Source files
------------

// File: rtl/mult_arbiter.sv
// rtl/mult_arbiter.sv - round-robin arbiter sharing one iterative 8x8 multiplier
//
// Grants one of N requesters at a time, latches its operands, runs the
// multiplier start/busy handshake and returns the product with a one-cycle
// one-hot done pulse to the granted requester.
//
// Ports:
//   clk           system clock, rising edge
//   reset         asynchronous active-low reset
//   req_bi        per-requester request level
//   a_bi, b_bi    flattened 8-bit operands, slice [8k+7:8k] = requester k
//   done_bo       one-hot one-cycle completion pulse
//   y_bo          product of the last completed job
//   gnt_idx_bo    index of the current or last granted requester
//   busy_o        high from grant through the done cycle
//   mult_a_bo     operand A to the multiplier
//   mult_b_bo     operand B to the multiplier
//   mult_start_o  start strobe to the multiplier
//   mult_busy_i   multiplier busy
//   mult_y_bi     multiplier product
module mult_arbiter #(
  parameter int N   = 4,
  parameter int IDW = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N-1:0]     req_bi,
  input  logic [8*N-1:0]   a_bi,
  input  logic [8*N-1:0]   b_bi,
  output logic [N-1:0]     done_bo,
  output logic [15:0]      y_bo,
  output logic [IDW-1:0]   gnt_idx_bo,
  output logic             busy_o,
  output logic [7:0]       mult_a_bo,
  output logic [7:0]       mult_b_bo,
  output logic             mult_start_o,
  input  logic             mult_busy_i,
  input  logic [15:0]      mult_y_bi
);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] ISSUE   = 3'd1;
  localparam logic [2:0] WAIT_HI = 3'd2;
  localparam logic [2:0] WAIT_LO = 3'd3;
  localparam logic [2:0] RESP    = 3'd4;

  logic [2:0]     state_q, state_d;
  logic [IDW-1:0] rr_ptr_q, rr_ptr_d;
  logic [N-1:0]   done_q, done_d;
  logic [15:0]    y_q, y_d;
  logic [IDW-1:0] gnt_q, gnt_d;
  logic           busy_q, busy_d;
  logic [7:0]     ma_q, ma_d;
  logic [7:0]     mb_q, mb_d;
  logic           start_q, start_d;

  logic           pick_valid;
  logic [IDW-1:0] pick_idx;
  logic [7:0]     pick_a;
  logic [7:0]     pick_b;
  int             k;

  // Wrap-around search starting at rr_ptr; the first set request wins.
  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = '0;
    pick_a     = '0;
    pick_b     = '0;
    k          = 0;
    for (int i = 0; i < N; i++) begin
      k = (int'(rr_ptr_q) + i) % N;
      if (!pick_valid && req_bi[k]) begin
        pick_valid = 1'b1;
        pick_idx   = IDW'(k);
        pick_a     = a_bi[k*8 +: 8];
        pick_b     = b_bi[k*8 +: 8];
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    done_d   = done_q;
    y_d      = y_q;
    gnt_d    = gnt_q;
    busy_d   = busy_q;
    ma_d     = ma_q;
    mb_d     = mb_q;
    start_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (pick_valid) begin
          gnt_d   = pick_idx;
          ma_d    = pick_a;
          mb_d    = pick_b;
          busy_d  = 1'b1;
          // Registered strobe: high exactly while the FSM sits in ISSUE.
          start_d = 1'b1;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        state_d = WAIT_HI;
      end
      WAIT_HI: begin
        if (mult_busy_i) state_d = WAIT_LO;
      end
      WAIT_LO: begin
        if (!mult_busy_i) begin
          y_d     = mult_y_bi;
          done_d  = N'(1) << gnt_q;
          state_d = RESP;
        end
      end
      RESP: begin
        done_d   = '0;
        busy_d   = 1'b0;
        rr_ptr_d = (gnt_q == IDW'(N-1)) ? '0 : gnt_q + 1'b1;
        state_d  = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
      done_q   <= '0;
      y_q      <= '0;
      gnt_q    <= '0;
      busy_q   <= 1'b0;
      ma_q     <= '0;
      mb_q     <= '0;
      start_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      done_q   <= done_d;
      y_q      <= y_d;
      gnt_q    <= gnt_d;
      busy_q   <= busy_d;
      ma_q     <= ma_d;
      mb_q     <= mb_d;
      start_q  <= start_d;
    end
  end

  assign done_bo      = done_q;
  assign y_bo         = y_q;
  assign gnt_idx_bo   = gnt_q;
  assign busy_o       = busy_q;
  assign mult_a_bo    = ma_q;
  assign mult_b_bo    = mb_q;
  assign mult_start_o = start_q;

endmodule

// File: tb/tb_mult_arbiter.sv
// tb/tb_mult_arbiter.sv - scoreboard bench for mult_arbiter with a multiplier model
module tb_mult_arbiter;

  localparam int N   = 4;
  localparam int IDW = 3;

  logic             clk = 1'b0;
  logic             reset;
  logic [N-1:0]     req_bi;
  logic [8*N-1:0]   a_bi;
  logic [8*N-1:0]   b_bi;
  logic [N-1:0]     done_bo;
  logic [15:0]      y_bo;
  logic [IDW-1:0]   gnt_idx_bo;
  logic             busy_o;
  logic [7:0]       mult_a_bo;
  logic [7:0]       mult_b_bo;
  logic             mult_start_o;
  logic             mult_busy_i;
  logic [15:0]      mult_y_bi;

  int errors = 0;
  int checks = 0;

  typedef struct {
    int          idx;
    logic [15:0] y;
  } exp_t;
  exp_t sb[$];

  mult_arbiter #(.N(N), .IDW(IDW)) dut (
    .clk          (clk),
    .reset        (reset),
    .req_bi       (req_bi),
    .a_bi         (a_bi),
    .b_bi         (b_bi),
    .done_bo      (done_bo),
    .y_bo         (y_bo),
    .gnt_idx_bo   (gnt_idx_bo),
    .busy_o       (busy_o),
    .mult_a_bo    (mult_a_bo),
    .mult_b_bo    (mult_b_bo),
    .mult_start_o (mult_start_o),
    .mult_busy_i  (mult_busy_i),
    .mult_y_bi    (mult_y_bi)
  );

  always #5 clk = ~clk;

  // Iterative multiplier model: samples on start, busy rises one edge later,
  // stays high a random number of cycles, product valid once busy falls.
  logic        m_pend;
  logic [15:0] m_prod;
  int          m_cnt;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_pend      <= 1'b0;
      mult_busy_i <= 1'b0;
      mult_y_bi   <= '0;
      m_prod      <= '0;
      m_cnt       <= 0;
    end else begin
      if (mult_start_o) begin
        m_pend <= 1'b1;
        m_prod <= {8'h00, mult_a_bo} * {8'h00, mult_b_bo};
      end
      if (m_pend) begin
        m_pend      <= 1'b0;
        mult_busy_i <= 1'b1;
        m_cnt       <= int'($urandom_range(1, 4));
        mult_y_bi   <= 16'hDEAD;
      end else if (mult_busy_i) begin
        if (m_cnt == 0) begin
          mult_busy_i <= 1'b0;
          mult_y_bi   <= m_prod;
        end else begin
          m_cnt <= m_cnt - 1;
        end
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every done pulse must match the oldest expected job.
  always @(negedge clk) begin
    if (reset && done_bo !== '0) begin
      if (sb.size() == 0) begin
        check("done_unexpected", 32'(done_bo), 32'h0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("done_onehot", 32'(done_bo), 32'(1) << e.idx);
        check("y_result", 32'(y_bo), 32'(e.y));
      end
    end
  end

  // The start strobe must never last two cycles.
  logic prev_start = 1'b0;
  always @(negedge clk) begin
    if (mult_start_o) check("start_single_cycle", 32'(prev_start), 32'h0);
    prev_start <= mult_start_o;
  end

  int start_count = 0;
  always @(negedge clk) if (mult_start_o) start_count++;

  task automatic wait_done(input bit drop);
    bit seen;
    seen = 1'b0;
    for (int c = 0; c < 200 && !seen; c++) begin
      @(negedge clk);
      if (done_bo !== '0) begin
        seen = 1'b1;
        if (drop) req_bi = req_bi & ~done_bo;
      end
    end
    if (!seen) check("done_timeout", 32'h0, 32'h1);
  endtask

  task automatic wait_mult_busy();
    bit seen;
    seen = 1'b0;
    for (int c = 0; c < 50 && !seen; c++) begin
      @(negedge clk);
      if (mult_busy_i) seen = 1'b1;
    end
    if (!seen) check("mult_busy_timeout", 32'h0, 32'h1);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_done"}, 32'(done_bo), 32'h0);
    check({tag, "_y"}, 32'(y_bo), 32'h0);
    check({tag, "_gnt"}, 32'(gnt_idx_bo), 32'h0);
    check({tag, "_busy"}, 32'(busy_o), 32'h0);
    check({tag, "_ma"}, 32'(mult_a_bo), 32'h0);
    check({tag, "_mb"}, 32'(mult_b_bo), 32'h0);
    check({tag, "_start"}, 32'(mult_start_o), 32'h0);
  endtask

  function automatic exp_t mk(input int idx, input int a, input int b);
    exp_t e;
    e.idx = idx;
    e.y   = 16'(a * b);
    return e;
  endfunction

  initial begin
    // Reset held with random inputs.
    reset  = 1'b0;
    req_bi = N'($urandom);
    a_bi   = $urandom;
    b_bi   = $urandom;
    repeat (4) @(negedge clk);
    check_all_zero("reset");

    // Release with no requests: nothing starts.
    req_bi = '0;
    reset  = 1'b1;
    repeat (6) @(negedge clk);
    check("idle_no_start", 32'(start_count), 32'h0);
    check("idle_busy", 32'(busy_o), 32'h0);

    // Single request from requester 0.
    a_bi[7:0] = 8'd8;
    b_bi[7:0] = 8'd8;
    sb.push_back(mk(0, 8, 8));
    req_bi = 4'b0001;
    @(negedge clk);
    check("single_start", 32'(mult_start_o), 32'h1);
    check("single_busy", 32'(busy_o), 32'h1);
    check("single_gnt", 32'(gnt_idx_bo), 32'h0);
    check("single_ma", 32'(mult_a_bo), 32'd8);
    check("single_mb", 32'(mult_b_bo), 32'd8);
    @(negedge clk);
    check("single_start_low", 32'(mult_start_o), 32'h0);
    wait_done(1'b1);
    @(negedge clk);
    check("single_busy_after", 32'(busy_o), 32'h0);
    check("single_done_after", 32'(done_bo), 32'h0);
    check("single_y_held", 32'(y_bo), 32'd64);

    // Pulse reset so the pointer restarts at 0 for the rotation test.
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    // All four requesting continuously: grants 0,1,2,3,0.
    a_bi = {8'd0, 8'd255, 8'd7, 8'd3};
    b_bi = {8'd200, 8'd255, 8'd9, 8'd5};
    sb.push_back(mk(0, 3, 5));
    sb.push_back(mk(1, 7, 9));
    sb.push_back(mk(2, 255, 255));
    sb.push_back(mk(3, 0, 200));
    sb.push_back(mk(0, 3, 5));
    req_bi = 4'b1111;
    for (int j = 0; j < 5; j++) wait_done(1'b0);
    req_bi = '0;
    @(negedge clk);

    // Serve requester 2 alone, then 0 and 1 together: 0 before 1.
    a_bi[23:16] = 8'd2;
    b_bi[23:16] = 8'd3;
    sb.push_back(mk(2, 2, 3));
    req_bi = 4'b0100;
    wait_done(1'b1);
    a_bi[7:0] = 8'd4;
    b_bi[7:0] = 8'd4;
    sb.push_back(mk(0, 4, 4));
    sb.push_back(mk(1, 7, 9));
    req_bi = 4'b0011;
    wait_done(1'b1);
    wait_done(1'b1);
    @(negedge clk);

    // Operand change during the job is ignored.
    a_bi[15:8] = 8'd12;
    b_bi[15:8] = 8'd12;
    sb.push_back(mk(1, 12, 12));
    req_bi = 4'b0010;
    wait_mult_busy();
    a_bi[15:8] = 8'd1;
    @(negedge clk);
    check("opchg_ma_latched", 32'(mult_a_bo), 32'd12);
    wait_done(1'b1);
    @(negedge clk);

    // Reset mid-job: no done, outputs cleared, next job completes normally.
    a_bi[7:0] = 8'd5;
    b_bi[7:0] = 8'd5;
    req_bi = 4'b0001;
    wait_mult_busy();
    reset  = 1'b0;
    req_bi = '0;
    #1;
    check_all_zero("midreset");
    repeat (3) @(negedge clk);
    a_bi[23:16] = 8'd9;
    b_bi[23:16] = 8'd7;
    sb.push_back(mk(2, 9, 7));
    reset  = 1'b1;
    req_bi = 4'b0100;
    @(negedge clk);
    check("midreset_regrant", 32'(gnt_idx_bo), 32'h2);
    wait_done(1'b1);
    repeat (3) @(negedge clk);

    check("scoreboard_empty", 32'(sb.size()), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    check("global_timeout", 32'h0, 32'h1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
